multicycle_controller: RTL and testbench

- Moore-style FSM that sequences a shared-datapath, multi-cycle RV32I subset core: one ALU, one unified memory, one register file.
- Replaces single-cycle control decode when the core is built in multi-cycle form.
- Issues per-state mux selects and write enables.
- Stalls on a memory ready handshake, counts retired instructions, and traps on unsupported opcodes.

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/mc_alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 166 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: states, ALU op classes,
// ALU control codes, opcodes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the FSM's ALU op class plus instruction fields to the ALU control code.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:  alucontrol = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // Only R-type (opb5=1) can encode sub; addi with imm[10]=1 stays add.
          3'b000:  alucontrol = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default:    alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared-datapath multi-cycle RV32I subset core:
// per-state selects/enables, memory-ready stalls, retire counter, sticky trap.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic [2:0]       ALUControl,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  state_t     cur, nxt;
  logic       pcupdate, branch, retire;
  logic       irwrite_s, regwrite_s, memwrite_s;
  logic [1:0] aluop;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    nxt        = cur;
    retire     = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    aluop      = ALUOP_ADD;
    case (cur)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        if (mem_ready) begin
          irwrite_s = 1'b1;
          pcupdate  = 1'b1;
          nxt       = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (Op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_JAL:       nxt = S_JAL;
          OP_BEQ:       nxt = S_BEQ;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        nxt     = Op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_READ;
        regwrite_s = 1'b1;
        nxt        = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_s = 1'b1;
        if (mem_ready) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_FUNC;
        nxt     = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNC;
        nxt     = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pcupdate = 1'b1;
        nxt      = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
        nxt        = S_FETCH;
        retire     = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        nxt     = S_FETCH;
        retire  = 1'b1;
      end
      S_ILLEGAL: nxt = S_ILLEGAL;
      default:   nxt = S_ILLEGAL;
    endcase
  end

  always_comb begin
    case (Op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7[5]),
    .opb5       (Op[5]),
    .alucontrol (ALUControl)
  );

  // Write enables are gated by rst so nothing architectural moves during reset.
  assign PCWrite  = (pcupdate | (branch & Zero)) & ~rst;
  assign IRWrite  = irwrite_s & ~rst;
  assign RegWrite = regwrite_s & ~rst;
  assign MemWrite = memwrite_s & ~rst;
  assign state    = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_FETCH;
      instret <= '0;
      trap    <= 1'b0;
    end else begin
      cur <= nxt;
      if (retire) instret <= instret + CNT_W'(1);
      if (nxt == S_ILLEGAL) trap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded directed bench for multicycle_controller (counter narrowed to 4 bits).
module tb_multicycle_controller;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, Zero, mem_ready;
  logic [6:0]    Op, funct7;
  logic [2:0]    funct3;
  logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, trap;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]    ALUControl;
  logic [CW-1:0] instret;
  logic [3:0]    state;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .trap(trap), .instret(instret), .state(state)
  );

  // we = {PCWrite, IRWrite, RegWrite, MemWrite}
  typedef struct packed {
    logic [3:0] st;
    logic [3:0] we;
    logic       adr;
    logic [1:0] rs;
    logic [2:0] alu;
    logic       tr;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  stim_q[$];
  int          nchecks = 0;
  int          nfail = 0;
  int unsigned retired = 0;
  string       step = "";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, expv);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic [3:0] we, input logic adr,
                      input logic [1:0] rs, input logic [2:0] alu, input logic tr,
                      input logic mr, input logic z);
    exp_q.push_back('{st, we, adr, rs, alu, tr});
    stim_q.push_back({mr, z});
  endtask

  task automatic drain();
    exp_t       e;
    logic [1:0] s;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      mem_ready = s[1];
      Zero      = s[0];
      #1;
      chk("state", 32'(state), 32'(e.st));
      chk("we", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'(e.we));
      chk("adrsrc", 32'(AdrSrc), 32'(e.adr));
      chk("resultsrc", 32'(ResultSrc), 32'(e.rs));
      chk("aluctl", 32'(ALUControl), 32'(e.alu));
      chk("trap", 32'(trap), 32'(e.tr));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ir(input string name, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [1:0] imm);
    step = name;
    Op = op; funct3 = f3; funct7 = f7;
    #1;
    chk("immsrc", 32'(ImmSrc), 32'(imm));
  endtask

  task automatic fetch(input int stalls);
    for (int i = 0; i < stalls; i++) push(4'd0, 4'b0000, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0);
    push(4'd0, 4'b1100, 1'b0, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
    push(4'd1, 4'b0000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic retire_chk();
    retired++;
    chk("instret", 32'(instret), retired & 32'hF);
  endtask

  task automatic do_r(input string name, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [2:0] alu);
    set_ir(name, 7'b0110011, f3, f7, 2'b00);
    fetch(0);
    push(4'd6, 4'b0000, 1'b0, 2'b00, alu, 1'b0, 1'b1, 1'b0);
    push(4'd7, 4'b0010, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
    drain();
    retire_chk();
  endtask

  task automatic do_i(input string name, input int fstall, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [2:0] alu);
    set_ir(name, 7'b0010011, f3, f7, 2'b00);
    fetch(fstall);
    push(4'd8, 4'b0000, 1'b0, 2'b00, alu, 1'b0, 1'b1, 1'b0);
    push(4'd7, 4'b0010, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
    drain();
    retire_chk();
  endtask

  task automatic do_lw(input int stalls);
    set_ir("lw", 7'b0000011, 3'b010, 7'b0, 2'b00);
    fetch(0);
    push(4'd2, 4'b0000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < stalls; i++) push(4'd3, 4'b0000, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    push(4'd3, 4'b0000, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
    push(4'd4, 4'b0010, 1'b0, 2'b01, 3'b000, 1'b0, 1'b1, 1'b0);
    drain();
    retire_chk();
  endtask

  task automatic do_sw(input int stalls);
    set_ir("sw", 7'b0100011, 3'b010, 7'b0, 2'b01);
    fetch(0);
    push(4'd2, 4'b0000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < stalls; i++) push(4'd5, 4'b0001, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    push(4'd5, 4'b0001, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
    drain();
    retire_chk();
  endtask

  task automatic do_jal();
    set_ir("jal", 7'b1101111, 3'b000, 7'b0, 2'b11);
    fetch(0);
    push(4'd9, 4'b1000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
    push(4'd7, 4'b0010, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
    drain();
    retire_chk();
  endtask

  task automatic do_beq(input string name, input logic z);
    set_ir(name, 7'b1100011, 3'b000, 7'b0, 2'b10);
    fetch(0);
    push(4'd10, {z, 3'b000}, 1'b0, 2'b00, 3'b001, 1'b0, 1'b1, z);
    drain();
    retire_chk();
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
    Op = 7'b0; funct3 = 3'b0; funct7 = 7'b0;
    step = "reset";
    repeat (2) @(posedge clk);
    #1;
    chk("state", 32'(state), 32'd0);
    chk("instret", 32'(instret), 32'd0);
    chk("trap", 32'(trap), 32'd0);
    chk("we_in_rst", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    rst = 1'b0;

    do_r("r_sub", 3'b000, 7'b0100000, 3'b001);
    do_lw(2);
    do_i("addi_f7", 1, 3'b000, 7'b0100000, 3'b000);
    do_sw(1);
    do_jal();
    do_beq("beq_taken", 1'b1);
    do_beq("beq_not", 1'b0);
    do_i("ori", 0, 3'b110, 7'b0, 3'b011);
    do_i("andi", 0, 3'b111, 7'b0, 3'b010);
    do_i("slti", 0, 3'b010, 7'b0, 3'b101);
    do_i("slli_dflt", 0, 3'b001, 7'b0, 3'b000);
    do_r("r_add", 3'b000, 7'b0000000, 3'b000);
    for (int i = 0; i < 6; i++) do_r("r_wrap", 3'b111, 7'b0, 3'b010);
    step = "wrap";
    chk("instret_wrapped", 32'(instret), 32'd2);

    set_ir("illegal", 7'b1111111, 3'b000, 7'b0, 2'b00);
    fetch(0);
    for (int i = 0; i < 20; i++) push(4'd11, 4'b0000, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1, 1'b1);
    drain();
    chk("instret_held", 32'(instret), retired & 32'hF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step = "illegal_rst";
    chk("state", 32'(state), 32'd0);
    chk("trap", 32'(trap), 32'd0);
    chk("instret", 32'(instret), 32'd0);
    rst = 1'b0;
    retired = 0;

    do_r("r_after_rst", 3'b110, 7'b0, 3'b011);
    set_ir("sw_rst", 7'b0100011, 3'b010, 7'b0, 2'b01);
    fetch(0);
    push(4'd2, 4'b0000, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0);
    push(4'd5, 4'b0001, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    drain();
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("memwrite_in_rst", 32'(MemWrite), 32'd0);
    chk("state_before", 32'(state), 32'd5);
    @(posedge clk);
    #1;
    chk("state", 32'(state), 32'd0);
    chk("memwrite", 32'(MemWrite), 32'd0);
    chk("instret", 32'(instret), 32'd0);
    rst = 1'b0;
    retired = 0;
    do_jal();

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
